// File: rtl/alu_imm_iq.sv
// alu_imm_iq: issue queue for the ALU reg-imm pipeline.
// Collapsing age-ordered queue (entry 0 oldest). Each cycle the oldest entry whose
// operand A is available (x0, already in PRF, bus forward or fast forward) is
// offered to the pipeline with its A source tagged.
// Optional feature macro: ALU_IMM_IQ_FAST_FORWARD_EN enables fast-forward wakeup;
// when undefined the fast_forward_* inputs are ignored.
module alu_imm_iq #(
   parameter int IQ_ENTRIES                  = 8,
   parameter int FAST_FORWARD_PIPE_COUNT     = 4,
   parameter int LOG_FAST_FORWARD_PIPE_COUNT = $clog2(FAST_FORWARD_PIPE_COUNT),
   parameter int PRF_BANK_COUNT              = 4,
   parameter int LOG_PRF_BANK_COUNT          = $clog2(PRF_BANK_COUNT),
   parameter int LOG_PR_COUNT                = 7,
   parameter int LOG_ROB_ENTRIES             = 7
) (
   input  logic                                    CLK,
   input  logic                                    RST,
   // dispatch
   input  logic                                    dispatch_valid,
   input  logic [3:0]                              dispatch_op,
   input  logic [11:0]                             dispatch_imm12,
   input  logic [LOG_PR_COUNT-1:0]                 dispatch_A_PR,
   input  logic                                    dispatch_A_ready,
   input  logic                                    dispatch_A_is_zero,
   input  logic [LOG_PR_COUNT-1:0]                 dispatch_dest_PR,
   input  logic [LOG_ROB_ENTRIES-1:0]              dispatch_ROB_index,
   output logic                                    dispatch_ready,
   // writeback bus forward notifications
   input  logic [PRF_BANK_COUNT-1:0]               WB_bus_valid_by_bank,
   input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
   // fast forward notifications
   input  logic [FAST_FORWARD_PIPE_COUNT-1:0]      fast_forward_notif_valid_by_pipe,
   input  logic [FAST_FORWARD_PIPE_COUNT-1:0][LOG_PR_COUNT-1:0] fast_forward_notif_PR_by_pipe,
   // issue bundle
   output logic                                    issue_valid,
   output logic [3:0]                              issue_op,
   output logic [11:0]                             issue_imm12,
   output logic                                    issue_A_is_reg,
   output logic                                    issue_A_is_bus_forward,
   output logic                                    issue_A_is_fast_forward,
   output logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0]  issue_A_fast_forward_pipe,
   output logic [LOG_PRF_BANK_COUNT-1:0]           issue_A_bank,
   output logic [LOG_PR_COUNT-1:0]                 issue_dest_PR,
   output logic [LOG_ROB_ENTRIES-1:0]              issue_ROB_index,
   input  logic                                    issue_ready,
   // PRF read request
   output logic                                    PRF_req_A_valid,
   output logic [LOG_PR_COUNT-1:0]                 PRF_req_A_PR
);

   localparam int UPPER_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
   localparam int CNT_W   = $clog2(IQ_ENTRIES + 1);
   localparam int IDX_W   = (IQ_ENTRIES > 1) ? $clog2(IQ_ENTRIES) : 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(IQ_ENTRIES);

   // control state
   logic [CNT_W-1:0]            r_count;
   logic                        r_dispatch_ready;

   // entry payload (not reset: validity comes from r_count)
   logic [3:0]                  r_op       [IQ_ENTRIES];
   logic [11:0]                 r_imm12    [IQ_ENTRIES];
   logic [LOG_PR_COUNT-1:0]     r_A_PR     [IQ_ENTRIES];
   logic                        r_A_ready  [IQ_ENTRIES];
   logic                        r_A_is_zero[IQ_ENTRIES];
   logic [LOG_PR_COUNT-1:0]     r_dest_PR  [IQ_ENTRIES];
   logic [LOG_ROB_ENTRIES-1:0]  r_ROB_index[IQ_ENTRIES];

   // next-state payload
   logic [3:0]                  w_n_op       [IQ_ENTRIES];
   logic [11:0]                 w_n_imm12    [IQ_ENTRIES];
   logic [LOG_PR_COUNT-1:0]     w_n_A_PR     [IQ_ENTRIES];
   logic                        w_n_A_ready  [IQ_ENTRIES];
   logic                        w_n_A_is_zero[IQ_ENTRIES];
   logic [LOG_PR_COUNT-1:0]     w_n_dest_PR  [IQ_ENTRIES];
   logic [LOG_ROB_ENTRIES-1:0]  w_n_ROB_index[IQ_ENTRIES];

   // wakeup / select
   logic [IQ_ENTRIES-1:0]                  w_valid;
   logic [IQ_ENTRIES-1:0]                  w_bus_hit;
   logic [IQ_ENTRIES-1:0]                  w_ff_hit;
   logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0] w_ff_pipe [IQ_ENTRIES];
   logic [IQ_ENTRIES-1:0]                  w_issuable;
   logic [IDX_W-1:0]                       w_sel;
   logic                                   w_any;
   logic                                   w_fire;
   logic                                   w_disp_fire;
   logic                                   w_disp_bus_hit;
   logic [LOG_PRF_BANK_COUNT-1:0]          w_disp_bank;
   logic [CNT_W-1:0]                       w_disp_idx;
   logic [CNT_W-1:0]                       w_count_next;

   assign dispatch_ready = r_dispatch_ready;

   // Bus-forward wakeup for stored entries: bank selects the bus, upper PR bits must match
   always_comb begin
      for (int i = 0; i < IQ_ENTRIES; i++) begin
         w_valid[i]   = (CNT_W'(i) < r_count);
         w_bus_hit[i] = WB_bus_valid_by_bank[r_A_PR[i][LOG_PRF_BANK_COUNT-1:0]] &&
                        (WB_bus_upper_PR_by_bank[r_A_PR[i][LOG_PRF_BANK_COUNT-1:0]] ==
                         r_A_PR[i][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
      end
   end

`ifdef ALU_IMM_IQ_FAST_FORWARD_EN
   // Fast-forward wakeup: scan pipes high to low so the lowest matching pipe wins
   always_comb begin
      for (int i = 0; i < IQ_ENTRIES; i++) begin
         w_ff_hit[i]  = 1'b0;
         w_ff_pipe[i] = '0;
         for (int p = FAST_FORWARD_PIPE_COUNT - 1; p >= 0; p--) begin
            if (fast_forward_notif_valid_by_pipe[p] &&
                (fast_forward_notif_PR_by_pipe[p] == r_A_PR[i])) begin
               w_ff_hit[i]  = 1'b1;
               w_ff_pipe[i] = LOG_FAST_FORWARD_PIPE_COUNT'(p);
            end
         end
      end
   end
`else
   logic w_unused_ff;
   assign w_unused_ff = ^{fast_forward_notif_valid_by_pipe, fast_forward_notif_PR_by_pipe};

   // Fast forward disabled: no entry ever wakes from a fast-forward notification
   always_comb begin
      for (int i = 0; i < IQ_ENTRIES; i++) begin
         w_ff_hit[i]  = 1'b0;
         w_ff_pipe[i] = '0;
      end
   end
`endif

   // Oldest-first select among entries whose operand A is available now
   always_comb begin
      w_sel = '0;
      w_any = 1'b0;
      for (int i = IQ_ENTRIES - 1; i >= 0; i--) begin
         w_issuable[i] = w_valid[i] &&
                         (r_A_is_zero[i] || r_A_ready[i] || w_bus_hit[i] || w_ff_hit[i]);
         if (w_issuable[i]) begin
            w_sel = IDX_W'(i);
            w_any = 1'b1;
         end
      end
   end

   assign w_fire         = w_any & issue_ready;
   assign w_disp_fire    = dispatch_valid & r_dispatch_ready;
   assign w_disp_bank    = dispatch_A_PR[LOG_PRF_BANK_COUNT-1:0];
   assign w_disp_bus_hit = WB_bus_valid_by_bank[w_disp_bank] &&
                           (WB_bus_upper_PR_by_bank[w_disp_bank] ==
                            dispatch_A_PR[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
   // the new op lands right after the surviving entries
   assign w_disp_idx     = r_count - CNT_W'(w_fire);
   assign w_count_next   = r_count - CNT_W'(w_fire) + CNT_W'(w_disp_fire);

   // Issue bundle: source priority x0 > PRF > bus forward > fast forward
   always_comb begin
      issue_valid               = w_any;
      issue_op                  = '0;
      issue_imm12               = '0;
      issue_A_is_reg            = 1'b0;
      issue_A_is_bus_forward    = 1'b0;
      issue_A_is_fast_forward   = 1'b0;
      issue_A_fast_forward_pipe = '0;
      issue_A_bank              = '0;
      issue_dest_PR             = '0;
      issue_ROB_index           = '0;
      PRF_req_A_valid           = 1'b0;
      PRF_req_A_PR              = '0;
      if (w_any) begin
         issue_op        = r_op[w_sel];
         issue_imm12     = r_imm12[w_sel];
         issue_dest_PR   = r_dest_PR[w_sel];
         issue_ROB_index = r_ROB_index[w_sel];
         if (r_A_is_zero[w_sel]) begin
            issue_A_is_reg = 1'b0;
         end else if (r_A_ready[w_sel]) begin
            issue_A_is_reg = 1'b1;
         end else if (w_bus_hit[w_sel]) begin
            issue_A_is_bus_forward = 1'b1;
            issue_A_bank           = r_A_PR[w_sel][LOG_PRF_BANK_COUNT-1:0];
         end else if (w_ff_hit[w_sel]) begin
            issue_A_is_fast_forward   = 1'b1;
            issue_A_fast_forward_pipe = w_ff_pipe[w_sel];
         end
         PRF_req_A_valid = issue_ready & issue_A_is_reg;
         if (PRF_req_A_valid) begin
            PRF_req_A_PR = r_A_PR[w_sel];
         end
      end
   end

   // Next payload: collapse above the issued slot, latch bus wakeups, insert dispatch
   always_comb begin
      for (int i = 0; i < IQ_ENTRIES; i++) begin
         w_n_op[i]        = r_op[i];
         w_n_imm12[i]     = r_imm12[i];
         w_n_A_PR[i]      = r_A_PR[i];
         w_n_A_ready[i]   = r_A_ready[i] | w_bus_hit[i];
         w_n_A_is_zero[i] = r_A_is_zero[i];
         w_n_dest_PR[i]   = r_dest_PR[i];
         w_n_ROB_index[i] = r_ROB_index[i];
      end
      for (int i = 0; i < IQ_ENTRIES - 1; i++) begin
         if (w_fire && (IDX_W'(i) >= w_sel)) begin
            w_n_op[i]        = r_op[i+1];
            w_n_imm12[i]     = r_imm12[i+1];
            w_n_A_PR[i]      = r_A_PR[i+1];
            w_n_A_ready[i]   = r_A_ready[i+1] | w_bus_hit[i+1];
            w_n_A_is_zero[i] = r_A_is_zero[i+1];
            w_n_dest_PR[i]   = r_dest_PR[i+1];
            w_n_ROB_index[i] = r_ROB_index[i+1];
         end
      end
      for (int i = 0; i < IQ_ENTRIES; i++) begin
         if (w_disp_fire && (CNT_W'(i) == w_disp_idx)) begin
            w_n_op[i]        = dispatch_op;
            w_n_imm12[i]     = dispatch_imm12;
            w_n_A_PR[i]      = dispatch_A_PR;
            w_n_A_ready[i]   = dispatch_A_ready | w_disp_bus_hit;
            w_n_A_is_zero[i] = dispatch_A_is_zero;
            w_n_dest_PR[i]   = dispatch_dest_PR;
            w_n_ROB_index[i] = dispatch_ROB_index;
         end
      end
   end

   // Occupancy and registered dispatch_ready (reset empties the queue)
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_count          <= '0;
         r_dispatch_ready <= 1'b1;
      end else begin
         r_count          <= w_count_next;
         r_dispatch_ready <= (w_count_next < FULL);
      end
   end

   // Entry payload registers
   always_ff @(posedge CLK) begin
      for (int i = 0; i < IQ_ENTRIES; i++) begin
         r_op[i]        <= w_n_op[i];
         r_imm12[i]     <= w_n_imm12[i];
         r_A_PR[i]      <= w_n_A_PR[i];
         r_A_ready[i]   <= w_n_A_ready[i];
         r_A_is_zero[i] <= w_n_A_is_zero[i];
         r_dest_PR[i]   <= w_n_dest_PR[i];
         r_ROB_index[i] <= w_n_ROB_index[i];
      end
   end

endmodule

// File: tb/tb_alu_imm_iq.sv
// tb_alu_imm_iq: directed scenarios plus randomized traffic for alu_imm_iq,
// checked every cycle against a queue-based reference model.
module tb_alu_imm_iq;

`ifdef ALU_IMM_IQ_FAST_FORWARD_EN
   localparam bit FF_EN = 1'b1;
`else
   localparam bit FF_EN = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            dispatch_valid = 1'b0;
   logic [3:0]      dispatch_op = '0;
   logic [11:0]     dispatch_imm12 = '0;
   logic [6:0]      dispatch_A_PR = '0;
   logic            dispatch_A_ready = 1'b0;
   logic            dispatch_A_is_zero = 1'b0;
   logic [6:0]      dispatch_dest_PR = '0;
   logic [6:0]      dispatch_ROB_index = '0;
   logic            dispatch_ready;
   logic [3:0]      WB_bus_valid_by_bank = '0;
   logic [3:0][4:0] WB_bus_upper_PR_by_bank = '0;
   logic [3:0]      fast_forward_notif_valid_by_pipe = '0;
   logic [3:0][6:0] fast_forward_notif_PR_by_pipe = '0;
   logic            issue_valid;
   logic [3:0]      issue_op;
   logic [11:0]     issue_imm12;
   logic            issue_A_is_reg;
   logic            issue_A_is_bus_forward;
   logic            issue_A_is_fast_forward;
   logic [1:0]      issue_A_fast_forward_pipe;
   logic [1:0]      issue_A_bank;
   logic [6:0]      issue_dest_PR;
   logic [6:0]      issue_ROB_index;
   logic            issue_ready = 1'b0;
   logic            PRF_req_A_valid;
   logic [6:0]      PRF_req_A_PR;

   alu_imm_iq dut (
      .CLK(CLK), .RST(RST),
      .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
      .dispatch_imm12(dispatch_imm12), .dispatch_A_PR(dispatch_A_PR),
      .dispatch_A_ready(dispatch_A_ready), .dispatch_A_is_zero(dispatch_A_is_zero),
      .dispatch_dest_PR(dispatch_dest_PR), .dispatch_ROB_index(dispatch_ROB_index),
      .dispatch_ready(dispatch_ready),
      .WB_bus_valid_by_bank(WB_bus_valid_by_bank),
      .WB_bus_upper_PR_by_bank(WB_bus_upper_PR_by_bank),
      .fast_forward_notif_valid_by_pipe(fast_forward_notif_valid_by_pipe),
      .fast_forward_notif_PR_by_pipe(fast_forward_notif_PR_by_pipe),
      .issue_valid(issue_valid), .issue_op(issue_op), .issue_imm12(issue_imm12),
      .issue_A_is_reg(issue_A_is_reg), .issue_A_is_bus_forward(issue_A_is_bus_forward),
      .issue_A_is_fast_forward(issue_A_is_fast_forward),
      .issue_A_fast_forward_pipe(issue_A_fast_forward_pipe),
      .issue_A_bank(issue_A_bank), .issue_dest_PR(issue_dest_PR),
      .issue_ROB_index(issue_ROB_index), .issue_ready(issue_ready),
      .PRF_req_A_valid(PRF_req_A_valid), .PRF_req_A_PR(PRF_req_A_PR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int op; int imm; int pr; bit rdy; bit zero; int dest; int rob;
   } ent_t;

   ent_t q[$];
   bit   exp_rdy = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   rob_ctr = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // bank = PR mod 4, upper = PR div 4
   function automatic bit bus_hit(input int pr);
      int b;
      b = pr % 4;
      return WB_bus_valid_by_bank[b] && (int'(WB_bus_upper_PR_by_bank[b]) == pr / 4);
   endfunction

   function automatic int ff_pipe(input int pr);
      if (!FF_EN) return -1;
      for (int p = 0; p < 4; p++)
         if (fast_forward_notif_valid_by_pipe[p] && int'(fast_forward_notif_PR_by_pipe[p]) == pr)
            return p;
      return -1;
   endfunction

   // Compare DUT outputs with the model for this cycle, then advance the model over the edge
   task automatic cycle_chk();
      int sel, issued, fp;
      bit is_reg, is_bus, is_ff;
      ent_t e, n;
      #1;
      sel = -1;
      foreach (q[k]) begin
         if (q[k].zero || q[k].rdy || bus_hit(q[k].pr) || ff_pipe(q[k].pr) >= 0) begin
            sel = k;
            break;
         end
      end
      check("disp_rdy", 32'(dispatch_ready), 32'(exp_rdy));
      check("iss_vld", 32'(issue_valid), 32'(sel >= 0));
      is_reg = 0;
      if (sel >= 0) begin
         e = q[sel];
         fp = ff_pipe(e.pr);
         is_reg = !e.zero && e.rdy;
         is_bus = !e.zero && !e.rdy && bus_hit(e.pr);
         is_ff  = !e.zero && !e.rdy && !is_bus && fp >= 0;
         check("iss_op", 32'(issue_op), e.op);
         check("iss_imm", 32'(issue_imm12), e.imm);
         check("iss_dest", 32'(issue_dest_PR), e.dest);
         check("iss_rob", 32'(issue_ROB_index), e.rob);
         check("is_reg", 32'(issue_A_is_reg), 32'(is_reg));
         check("is_bus", 32'(issue_A_is_bus_forward), 32'(is_bus));
         check("is_ff", 32'(issue_A_is_fast_forward), 32'(is_ff));
         if (is_bus) check("a_bank", 32'(issue_A_bank), e.pr % 4);
         if (is_ff) check("ff_pipe", 32'(issue_A_fast_forward_pipe), fp);
      end
      check("prf_vld", 32'(PRF_req_A_valid), 32'(sel >= 0 && issue_ready && is_reg));
      if (sel >= 0 && issue_ready && is_reg) check("prf_pr", 32'(PRF_req_A_PR), q[sel].pr);
      issued = (sel >= 0 && issue_ready) ? sel : -1;
      foreach (q[k]) if (k != issued && bus_hit(q[k].pr)) q[k].rdy = 1'b1;
      if (issued >= 0) q.delete(issued);
      if (dispatch_valid && exp_rdy) begin
         n.op = dispatch_op; n.imm = dispatch_imm12; n.pr = dispatch_A_PR;
         n.rdy = dispatch_A_ready || bus_hit(dispatch_A_PR);
         n.zero = dispatch_A_is_zero; n.dest = dispatch_dest_PR; n.rob = dispatch_ROB_index;
         q.push_back(n);
      end
      exp_rdy = (q.size() < 8);
      @(negedge CLK);
   endtask

   task automatic clr_in();
      dispatch_valid = 0; issue_ready = 0;
      WB_bus_valid_by_bank = '0; WB_bus_upper_PR_by_bank = '0;
      fast_forward_notif_valid_by_pipe = '0; fast_forward_notif_PR_by_pipe = '0;
   endtask

   task automatic disp(input int op, input int imm, input int pr, input bit rdy,
                       input bit zero, input int rob);
      dispatch_valid = 1; dispatch_op = 4'(op); dispatch_imm12 = 12'(imm);
      dispatch_A_PR = 7'(pr); dispatch_A_ready = rdy; dispatch_A_is_zero = zero;
      dispatch_dest_PR = 7'(pr + 40); dispatch_ROB_index = 7'(rob);
   endtask

   // Asynchronous reset pulse between clock edges
   task automatic do_reset();
      clr_in();
      RST = 1;
      #1;
      q.delete();
      exp_rdy = 1'b1;
      check("rst_iss_vld", 32'(issue_valid), 0);
      check("rst_disp_rdy", 32'(dispatch_ready), 1);
      check("rst_prf_vld", 32'(PRF_req_A_valid), 0);
      @(negedge CLK);
      RST = 0;
   endtask

   initial begin
      @(negedge CLK);
      do_reset();

      // 1: ready operand issues next cycle from the PRF
      disp(0, 12'h7FF, 5, 1, 0, 1); issue_ready = 1;
      cycle_chk();
      dispatch_valid = 0;
      #1;
      check("t1_is_reg", 32'(issue_A_is_reg), 1);
      check("t1_prf_vld", 32'(PRF_req_A_valid), 1);
      check("t1_prf_pr", 32'(PRF_req_A_PR), 5);
      check("t1_imm", 32'(issue_imm12), 32'h7FF);
      cycle_chk();

      // 2: waiting operand wakes from bus bank 1, upper 2
      disp(3, 12, 9, 0, 0, 2);
      cycle_chk();
      dispatch_valid = 0;
      for (int c = 0; c < 3; c++) cycle_chk();
      WB_bus_valid_by_bank = 4'b0010; WB_bus_upper_PR_by_bank[1] = 5'd2;
      #1;
      check("t2_vld", 32'(issue_valid), 1);
      check("t2_bus", 32'(issue_A_is_bus_forward), 1);
      check("t2_bank", 32'(issue_A_bank), 1);
      cycle_chk();
      clr_in(); issue_ready = 1;

      // 3: fast forward from pipe 2
      disp(4, 33, 12, 0, 0, 3);
      cycle_chk();
      dispatch_valid = 0;
      fast_forward_notif_valid_by_pipe = 4'b0100; fast_forward_notif_PR_by_pipe[2] = 7'd12;
      #1;
      check("t3_vld", 32'(issue_valid), 32'(FF_EN));
      if (FF_EN) begin
         check("t3_ff", 32'(issue_A_is_fast_forward), 1);
         check("t3_pipe", 32'(issue_A_fast_forward_pipe), 2);
      end
      cycle_chk();
      clr_in(); issue_ready = 1;
      WB_bus_valid_by_bank = 4'b0001; WB_bus_upper_PR_by_bank[0] = 5'd3;
      cycle_chk();
      clr_in(); issue_ready = 1;
      cycle_chk();

      // 4: fill while stalled, then drain in age order
      issue_ready = 0;
      for (int k = 0; k < 8; k++) begin
         disp(k, k, k, 1, 0, k);
         cycle_chk();
      end
      dispatch_valid = 0;
      #1;
      check("t4_full_rdy", 32'(dispatch_ready), 0);
      check("t4_hold_vld", 32'(issue_valid), 1);
      check("t4_hold_rob", 32'(issue_ROB_index), 0);
      cycle_chk();
      issue_ready = 1;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("t4_order", 32'(issue_ROB_index), k);
         cycle_chk();
      end

      // 5: younger ready op bypasses older, concurrent dispatch keeps age order
      clr_in();
      disp(1, 1, 20, 0, 0, 32'h20); cycle_chk();
      disp(2, 2, 21, 1, 0, 32'h21); cycle_chk();
      disp(3, 3, 22, 1, 0, 32'h22); issue_ready = 1;
      #1; check("t5_first", 32'(issue_ROB_index), 32'h21);
      cycle_chk();
      dispatch_valid = 0;
      #1; check("t5_second", 32'(issue_ROB_index), 32'h22);
      cycle_chk();
      WB_bus_valid_by_bank = 4'b0001; WB_bus_upper_PR_by_bank[0] = 5'd5;
      #1; check("t5_third", 32'(issue_ROB_index), 32'h20);
      cycle_chk();

      // 6: reset with 5 entries queued; woken stale entries must not issue
      clr_in();
      for (int k = 0; k < 5; k++) begin
         disp(k, k, 30, 0, 0, 50 + k);
         cycle_chk();
      end
      do_reset();
      issue_ready = 1;
      WB_bus_valid_by_bank = 4'b0100; WB_bus_upper_PR_by_bank[2] = 5'd7;
      for (int c = 0; c < 3; c++) begin
         #1; check("t6_no_stale", 32'(issue_valid), 0);
         cycle_chk();
      end

      // randomized traffic
      clr_in();
      for (int c = 0; c < 2000; c++) begin
         if (c == 900) do_reset();
         if ($urandom_range(0, 9) < 6) begin
            disp($urandom_range(0, 15), $urandom_range(0, 4095), $urandom_range(0, 15),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), rob_ctr);
            rob_ctr = (rob_ctr + 1) % 128;
         end else begin
            dispatch_valid = 0;
         end
         issue_ready = (c % 200 < 40) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
         for (int b = 0; b < 4; b++) begin
            WB_bus_valid_by_bank[b] = ($urandom_range(0, 5) == 0);
            WB_bus_upper_PR_by_bank[b] = 5'($urandom_range(0, 3));
         end
         for (int p = 0; p < 4; p++) begin
            fast_forward_notif_valid_by_pipe[p] = ($urandom_range(0, 7) == 0);
            fast_forward_notif_PR_by_pipe[p] = 7'($urandom_range(0, 15));
         end
         cycle_chk();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
